// File: rtl/std_switch_pkg.sv
// ---------------------------------------------------------------------------
// std_switch_pkg : shared sequencer states and VIC-II chip model codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package std_switch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RLEAD  = 3'd1,
    GOFF   = 3'd2,
    SWITCH = 3'd3,
    GWAIT  = 3'd4,
    RHOLD  = 3'd5
  } seq_state_t;

  // Bit 0 of the code selects the clock family: 0 = NTSC, 1 = PAL.
  localparam logic [1:0] NTSC_6567R8   = 2'd0;
  localparam logic [1:0] PAL_6569      = 2'd1;
  localparam logic [1:0] NTSC_6567R56A = 2'd2;
  localparam logic [1:0] PAL_6572      = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/std_switch_ctl_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce : two-flop synchroniser, debounce counter and change pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sw_debounce
  import std_switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic i_clk_dot4x_ntsc,
  input  logic i_rst,
  input  logic i_standard_sw,
  output logic o_change
);

  localparam int                c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_cand;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_stable;
  logic               r_baseline;
  logic               r_change;

  always_ff @(posedge i_clk_dot4x_ntsc) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_cand     <= 1'b0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_baseline <= 1'b0;
      r_change   <= 1'b0;
    end else begin
      r_sync1  <= i_standard_sw;
      r_sync2  <= r_sync1;
      r_change <= 1'b0;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end else begin
        // Counter saturates; the first accepted level only seeds the baseline.
        r_stable   <= r_cand;
        r_baseline <= 1'b1;
        if (r_baseline && (r_cand != r_stable)) begin
          r_change <= 1'b1;
        end
      end
    end
  end

  assign o_change = r_change;

endmodule

`default_nettype wire

// File: rtl/std_switch_ctl.sv
// ---------------------------------------------------------------------------
// std_switch_ctl : glitch-safe video-standard / clock-mux switch sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module std_switch_ctl
  import std_switch_pkg::*;
#(
  parameter int CHIP_W          = 2,
  parameter int NUM_CHIPS       = 4,
  parameter int DEFAULT_CHIP    = 0,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int RST_LEAD        = 16,
  parameter int GATE_CYCLES     = 8,
  parameter int RST_HOLD        = 1024
) (
  input  logic              clk_dot4x_ntsc,
  input  logic              rst,
  input  logic              standard_sw,
  input  logic              sw_enable,
  input  logic [CHIP_W-1:0] cfg_chip,
  input  logic              cfg_load,
  output logic [CHIP_W-1:0] chip,
  output logic              clk_ce,
  output logic              cpu_reset_req,
  output logic              busy
);

  localparam int                c_SEQ_MAX  = max3(RST_LEAD, GATE_CYCLES, RST_HOLD);
  localparam int                c_SEQ_W    = $clog2(c_SEQ_MAX + 1);
  localparam logic [c_SEQ_W-1:0] c_LEAD_LD = c_SEQ_W'(RST_LEAD - 1);
  localparam logic [c_SEQ_W-1:0] c_GATE_LD = c_SEQ_W'(GATE_CYCLES - 1);
  localparam logic [c_SEQ_W-1:0] c_HOLD_LD = c_SEQ_W'(RST_HOLD - 1);
  localparam logic [CHIP_W-1:0]  c_DEFAULT = CHIP_W'(DEFAULT_CHIP);
  localparam logic [CHIP_W-1:0]  c_FAMILY  = CHIP_W'(1);

  seq_state_t          r_state;
  logic [c_SEQ_W-1:0]  r_cnt;
  logic [CHIP_W-1:0]   r_target;
  logic [CHIP_W-1:0]   r_pend_chip;
  logic                r_pend_valid;

  logic                w_db_change;
  logic                w_sw_change;
  logic [CHIP_W-1:0]   w_flip_chip;
  logic                w_req_valid;
  logic [CHIP_W-1:0]   w_req_chip;
  logic [CHIP_W-1:0]   w_go_chip;
  logic                w_go;

  function automatic logic code_ok(input logic [CHIP_W-1:0] code);
    return (32'(code) < 32'(NUM_CHIPS));
  endfunction

  sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk_dot4x_ntsc (clk_dot4x_ntsc),
    .i_rst            (rst),
    .i_standard_sw    (standard_sw),
    .o_change         (w_db_change)
  );

  assign w_sw_change = w_db_change & sw_enable;
  // A flip stacks on top of a queued request rather than the live model.
  assign w_flip_chip = (r_pend_valid ? r_pend_chip : chip) ^ c_FAMILY;

  always_comb begin
    w_req_valid = 1'b0;
    w_req_chip  = chip;
    if (cfg_load && code_ok(cfg_chip)) begin
      w_req_valid = 1'b1;
      w_req_chip  = cfg_chip;
    end else if (w_sw_change && code_ok(w_flip_chip)) begin
      w_req_valid = 1'b1;
      w_req_chip  = w_flip_chip;
    end
    if (w_req_valid && !r_pend_valid && (w_req_chip == chip)) begin
      w_req_valid = 1'b0;
    end
  end

  assign w_go_chip = w_req_valid ? w_req_chip : r_pend_chip;
  assign w_go      = (w_req_valid || r_pend_valid) && (w_go_chip != chip);

  always_ff @(posedge clk_dot4x_ntsc) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_target      <= c_DEFAULT;
      r_pend_chip   <= c_DEFAULT;
      r_pend_valid  <= 1'b0;
      chip          <= c_DEFAULT;
      clk_ce        <= 1'b1;
      cpu_reset_req <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (r_state != IDLE && w_req_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_chip  <= w_req_chip;
      end
      case (r_state)
        IDLE: begin
          r_pend_valid <= 1'b0;
          if (w_go) begin
            r_target      <= w_go_chip;
            r_state       <= RLEAD;
            r_cnt         <= c_LEAD_LD;
            cpu_reset_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
        RLEAD: begin
          if (r_cnt == '0) begin
            r_state <= GOFF;
            r_cnt   <= '0;
            clk_ce  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_SEQ_W'(1);
          end
        end
        GOFF: begin
          // The gate has been low for a full cycle before the mux select moves.
          r_state <= SWITCH;
          r_cnt   <= '0;
          chip    <= r_target;
        end
        SWITCH: begin
          r_state <= GWAIT;
          r_cnt   <= c_GATE_LD;
        end
        GWAIT: begin
          if (r_cnt == '0) begin
            r_state <= RHOLD;
            r_cnt   <= c_HOLD_LD;
            clk_ce  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_SEQ_W'(1);
          end
        end
        RHOLD: begin
          if (r_cnt == '0) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            cpu_reset_req <= 1'b0;
            busy          <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_SEQ_W'(1);
          end
        end
        default: begin
          r_state       <= IDLE;
          r_cnt         <= '0;
          clk_ce        <= 1'b1;
          cpu_reset_req <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
